// File: rtl/rggen_rtl_pkg.sv
// Shared types and helpers for the rggen register-access fabric.
package rggen_rtl_pkg;

    typedef enum logic [1:0] {
        RGGEN_OKAY          = 2'd0,
        RGGEN_EXOKAY        = 2'd1,
        RGGEN_SLAVE_ERROR   = 2'd2,
        RGGEN_TIMEOUT_ERROR = 2'd3
    } rggen_status;

    localparam int RGGEN_MAX_HOSTS = 8;

    // Index of the first set bit at or after start, wrapping modulo hosts.
    // Returns start when nothing is set; callers qualify with |request.
    function automatic logic [2:0] rggen_rr_select(
        input logic [RGGEN_MAX_HOSTS-1:0] request,
        input logic [2:0]                 start,
        input int                         hosts
    );
        logic [2:0] sel;
        int         idx;
        sel = start;
        // Walk offsets from the far end so the nearest hit wins.
        for (int i = RGGEN_MAX_HOSTS - 1; i >= 0; i--) begin
            if (i < hosts) begin
                idx = (int'(start) + i) % hosts;
                if (request[idx[2:0]]) begin
                    sel = idx[2:0];
                end
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/rggen_round_robin_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, pointer advances past the
// granted host on i_update.
module rggen_round_robin_arbiter
    import rggen_rtl_pkg::*;
#(
    parameter int HOSTS = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [HOSTS-1:0] i_request,
    input  logic             i_update,
    output logic [HOSTS-1:0] o_grant
);

    localparam int PW = (HOSTS > 1) ? $clog2(HOSTS) : 1;

    logic [PW-1:0]              pointer_q;
    logic [PW-1:0]              pointer_d;
    logic [RGGEN_MAX_HOSTS-1:0] request_ext;
    logic [2:0]                 select;

    always_comb begin
        request_ext              = '0;
        request_ext[HOSTS-1:0]   = i_request;
        select                   = rggen_rr_select(request_ext, 3'(pointer_q), HOSTS);
        o_grant                  = (|i_request) ? (HOSTS'(1) << select) : '0;
        pointer_d                = PW'((int'(select) + 1) % HOSTS);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pointer_q <= '0;
        end else if (i_update && (|i_request)) begin
            pointer_q <= pointer_d;
        end
    end

endmodule

// File: rtl/rggen_host_access_arbiter.sv
// Shares one register-block access port between several hosts with round-robin
// arbitration, grant held for the whole access, and an optional timeout.
module rggen_host_access_arbiter
    import rggen_rtl_pkg::*;
#(
    parameter int HOSTS          = 2,
    parameter int ADDRESS_WIDTH  = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [HOSTS-1:0]               i_request,
    input  logic [HOSTS-1:0]               i_write,
    input  logic [HOSTS*ADDRESS_WIDTH-1:0] i_address,
    input  logic [HOSTS*DATA_WIDTH-1:0]    i_write_data,
    input  logic [HOSTS*DATA_WIDTH-1:0]    i_strobe,
    output logic [HOSTS-1:0]               o_done,
    output logic [DATA_WIDTH-1:0]          o_read_data,
    output logic [1:0]                     o_status,
    output logic [HOSTS-1:0]               o_grant,
    output logic                           o_busy,
    output logic                           o_request,
    output logic                           o_write,
    output logic [ADDRESS_WIDTH-1:0]       o_address,
    output logic [DATA_WIDTH-1:0]          o_write_data,
    output logic [DATA_WIDTH-1:0]          o_strobe,
    input  logic                           i_done,
    input  logic [DATA_WIDTH-1:0]          i_read_data,
    input  logic [1:0]                     i_status
);

    localparam int COUNT_WIDTH = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {StIdle, StBusy, StRespond} state_e;

    state_e                   state_q;
    logic [COUNT_WIDTH-1:0]   count_q;
    logic                     timeout_hit;
    logic [HOSTS-1:0]         arb_request;
    logic [HOSTS-1:0]         arb_grant;
    logic                     sel_write;
    logic [ADDRESS_WIDTH-1:0] sel_address;
    logic [DATA_WIDTH-1:0]    sel_write_data;
    logic [DATA_WIDTH-1:0]    sel_strobe;

    // In RESPOND the arbiter sees only the owner, so the pointer moves past it
    // even if other hosts raised requests during the access.
    assign arb_request = (state_q == StRespond) ? o_grant : i_request;
    assign timeout_hit = (TIMEOUT_CYCLES > 0) && ((int'(count_q) + 1) >= TIMEOUT_CYCLES);

    rggen_round_robin_arbiter #(
        .HOSTS (HOSTS)
    ) u_arbiter (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_request (arb_request),
        .i_update  (state_q == StRespond),
        .o_grant   (arb_grant)
    );

    always_comb begin
        sel_write      = 1'b0;
        sel_address    = '0;
        sel_write_data = '0;
        sel_strobe     = '0;
        for (int h = 0; h < HOSTS; h++) begin
            if (arb_grant[h]) begin
                sel_write      = i_write[h];
                sel_address    = i_address[h*ADDRESS_WIDTH+:ADDRESS_WIDTH];
                sel_write_data = i_write_data[h*DATA_WIDTH+:DATA_WIDTH];
                sel_strobe     = i_strobe[h*DATA_WIDTH+:DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            count_q      <= '0;
            o_done       <= '0;
            o_read_data  <= '0;
            o_status     <= RGGEN_OKAY;
            o_grant      <= '0;
            o_busy       <= 1'b0;
            o_request    <= 1'b0;
            o_write      <= 1'b0;
            o_address    <= '0;
            o_write_data <= '0;
            o_strobe     <= '0;
        end else begin
            o_done      <= '0;
            o_read_data <= '0;
            o_status    <= RGGEN_OKAY;
            unique case (state_q)
                StIdle: begin
                    if (|i_request) begin
                        state_q      <= StBusy;
                        o_grant      <= arb_grant;
                        o_busy       <= 1'b1;
                        o_request    <= 1'b1;
                        o_write      <= sel_write;
                        o_address    <= sel_address;
                        o_write_data <= sel_write_data;
                        o_strobe     <= sel_strobe;
                    end
                end
                StBusy: begin
                    if (i_done) begin
                        state_q     <= StRespond;
                        o_request   <= 1'b0;
                        o_done      <= o_grant;
                        o_read_data <= i_read_data;
                        o_status    <= i_status;
                    end else if (timeout_hit) begin
                        state_q   <= StRespond;
                        o_request <= 1'b0;
                        o_done    <= o_grant;
                        o_status  <= RGGEN_TIMEOUT_ERROR;
                    end else if (TIMEOUT_CYCLES > 0) begin
                        count_q <= count_q + COUNT_WIDTH'(1);
                    end
                end
                StRespond: begin
                    state_q <= StIdle;
                    count_q <= '0;
                    o_grant <= '0;
                    o_busy  <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_rggen_host_access_arbiter.sv
// Directed self-checking bench for rggen_host_access_arbiter (2 hosts, timeout 4).
module tb_rggen_host_access_arbiter;

    localparam int HOSTS = 2;
    localparam int AW    = 16;
    localparam int DW    = 32;

    logic                  clk;
    logic                  rst_n;
    logic [HOSTS-1:0]      i_request;
    logic [HOSTS-1:0]      i_write;
    logic [HOSTS*AW-1:0]   i_address;
    logic [HOSTS*DW-1:0]   i_write_data;
    logic [HOSTS*DW-1:0]   i_strobe;
    logic [HOSTS-1:0]      o_done;
    logic [DW-1:0]         o_read_data;
    logic [1:0]            o_status;
    logic [HOSTS-1:0]      o_grant;
    logic                  o_busy;
    logic                  o_request;
    logic                  o_write;
    logic [AW-1:0]         o_address;
    logic [DW-1:0]         o_write_data;
    logic [DW-1:0]         o_strobe;
    logic                  i_done;
    logic [DW-1:0]         i_read_data;
    logic [1:0]            i_status;

    int checks = 0;
    int errors = 0;

    rggen_host_access_arbiter #(
        .HOSTS          (HOSTS),
        .ADDRESS_WIDTH  (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_request    (i_request),
        .i_write      (i_write),
        .i_address    (i_address),
        .i_write_data (i_write_data),
        .i_strobe     (i_strobe),
        .o_done       (o_done),
        .o_read_data  (o_read_data),
        .o_status     (o_status),
        .o_grant      (o_grant),
        .o_busy       (o_busy),
        .o_request    (o_request),
        .o_write      (o_write),
        .o_address    (o_address),
        .o_write_data (o_write_data),
        .o_strobe     (o_strobe),
        .i_done       (i_done),
        .i_read_data  (i_read_data),
        .i_status     (i_status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic set_host(input int h, input logic wr, input logic [AW-1:0] addr,
                            input logic [DW-1:0] data, input logic [DW-1:0] strb);
        i_write[h]                  = wr;
        i_address[h*AW+:AW]         = addr;
        i_write_data[h*DW+:DW]      = data;
        i_strobe[h*DW+:DW]          = strb;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_grant"}, 64'(o_grant), 64'd0);
        check({tag, "_busy"}, 64'(o_busy), 64'd0);
        check({tag, "_request"}, 64'(o_request), 64'd0);
        check({tag, "_done"}, 64'(o_done), 64'd0);
        check({tag, "_status"}, 64'(o_status), 64'd0);
        check({tag, "_rdata"}, 64'(o_read_data), 64'd0);
        check({tag, "_write"}, 64'(o_write), 64'd0);
        check({tag, "_addr"}, 64'(o_address), 64'd0);
        check({tag, "_wdata"}, 64'(o_write_data), 64'd0);
        check({tag, "_strobe"}, 64'(o_strobe), 64'd0);
    endtask

    initial begin
        logic [HOSTS-1:0] exp_grant;
        rst_n        = 1'b0;
        i_request    = '0;
        i_write      = '0;
        i_address    = '0;
        i_write_data = '0;
        i_strobe     = '0;
        i_done       = 1'b0;
        i_read_data  = '0;
        i_status     = 2'd0;
        step();
        step();
        check_all_zero("reset");
        rst_n = 1'b1;

        // Host 0 write, i_done two cycles after o_request
        set_host(0, 1'b1, 16'h0010, 32'hA5A5_0000, 32'hFFFF_0000);
        set_host(1, 1'b0, 16'h0F0F, 32'h1111_2222, 32'h0000_FFFF);
        i_request = 2'b01;
        step();
        check("t1_request", 64'(o_request), 64'd1);
        check("t1_grant", 64'(o_grant), 64'h1);
        check("t1_busy", 64'(o_busy), 64'd1);
        check("t1_write", 64'(o_write), 64'd1);
        check("t1_addr", 64'(o_address), 64'h0010);
        check("t1_wdata", 64'(o_write_data), 64'hA5A5_0000);
        check("t1_strobe", 64'(o_strobe), 64'hFFFF_0000);
        step();
        check("t1_hold_request", 64'(o_request), 64'd1);
        check("t1_no_early_done", 64'(o_done), 64'd0);
        step();
        i_done      = 1'b1;
        i_read_data = 32'h1234_5678;
        i_status    = 2'd0;
        step();
        i_done    = 1'b0;
        check("t1_done", 64'(o_done), 64'h1);
        check("t1_status", 64'(o_status), 64'd0);
        check("t1_request_drop", 64'(o_request), 64'd0);
        check("t1_busy_respond", 64'(o_busy), 64'd1);
        i_request = 2'b00;
        step();
        check("t1_idle_done", 64'(o_done), 64'd0);
        check("t1_idle_grant", 64'(o_grant), 64'd0);
        check("t1_idle_busy", 64'(o_busy), 64'd0);
        check("t1_idle_rdata", 64'(o_read_data), 64'd0);

        // Host 1 read with slave error
        set_host(1, 1'b0, 16'h0020, 32'h0, 32'h0);
        i_request = 2'b10;
        step();
        check("t3_grant", 64'(o_grant), 64'h2);
        check("t3_write", 64'(o_write), 64'd0);
        check("t3_addr", 64'(o_address), 64'h0020);
        i_done      = 1'b1;
        i_read_data = 32'hDEAD_BEEF;
        i_status    = 2'd2;
        step();
        i_done    = 1'b0;
        check("t3_done", 64'(o_done), 64'h2);
        check("t3_rdata", 64'(o_read_data), 64'hDEAD_BEEF);
        check("t3_status", 64'(o_status), 64'd2);
        i_request = 2'b00;
        step();
        check("t3_idle_rdata", 64'(o_read_data), 64'd0);
        check("t3_idle_status", 64'(o_status), 64'd0);

        // Both hosts from reset, held continuously: grants alternate 0,1,0,1
        rst_n = 1'b0;
        step();
        rst_n     = 1'b1;
        i_request = 2'b11;
        exp_grant = 2'b01;
        for (int n = 0; n < 4; n++) begin
            step();
            check("t2_grant", 64'(o_grant), 64'(exp_grant));
            i_done   = 1'b1;
            i_status = 2'd0;
            step();
            i_done = 1'b0;
            check("t2_done", 64'(o_done), 64'(exp_grant));
            step();
            check("t2_idle_grant", 64'(o_grant), 64'd0);
            exp_grant = {exp_grant[0], exp_grant[1]};
        end
        i_request = 2'b00;

        // Timeout with i_done never asserted
        i_read_data = 32'hFFFF_FFFF;
        i_status    = 2'd1;
        i_request   = 2'b01;
        step();
        check("t4_busy1_request", 64'(o_request), 64'd1);
        for (int n = 0; n < 3; n++) begin
            step();
            check("t4_busyn_request", 64'(o_request), 64'd1);
        end
        step();
        check("t4_request_drop", 64'(o_request), 64'd0);
        check("t4_done", 64'(o_done), 64'h1);
        check("t4_status", 64'(o_status), 64'd3);
        check("t4_rdata", 64'(o_read_data), 64'd0);
        i_request = 2'b00;
        step();

        // i_done in BUSY cycle 4 wins over the timeout
        i_request = 2'b10;
        step();
        step();
        step();
        step();
        i_done      = 1'b1;
        i_read_data = 32'h0BAD_F00D;
        i_status    = 2'd1;
        step();
        i_done = 1'b0;
        check("t5_done", 64'(o_done), 64'h2);
        check("t5_status", 64'(o_status), 64'd1);
        check("t5_rdata", 64'(o_read_data), 64'h0BAD_F00D);
        i_request = 2'b00;
        step();

        // Reset mid-access: outputs clear, no o_done, pointer back to host 0
        set_host(0, 1'b1, 16'h0030, 32'h0000_0001, 32'h0000_000F);
        i_request = 2'b01;
        step();
        i_done = 1'b1;
        step();
        i_done = 1'b0;
        check("t6_pre_done", 64'(o_done), 64'h1);
        i_request = 2'b00;
        step();
        set_host(1, 1'b1, 16'h0040, 32'hCAFE_0000, 32'hFFFF_FFFF);
        i_request = 2'b10;
        step();
        check("t6_grant_h1", 64'(o_grant), 64'h2);
        rst_n  = 1'b0;
        i_done = 1'b1;
        step();
        check_all_zero("t6_reset");
        rst_n     = 1'b1;
        i_done    = 1'b0;
        i_request = 2'b11;
        step();
        check("t6_regrant", 64'(o_grant), 64'h1);
        check("t6_no_done", 64'(o_done), 64'd0);
        i_done = 1'b1;
        step();
        i_done    = 1'b0;
        i_request = 2'b00;
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rggen_host_access_arbiter.md
Name: rggen_host_access_arbiter

Overview:
Shares one register-block access port between HOSTS independent requesters, e.g. a CPU bus bridge and a debug port. It applies round-robin arbitration and holds the grant for the whole access. An optional timeout aborts accesses that are never completed. It sits between the host-side bus adapters and the register block feeding the set/clear-style bit fields.

Parameters:
HOSTS, 2, number of requesters; legal range 1..8.
ADDRESS_WIDTH, 16, access address width.
DATA_WIDTH, 32, data and strobe width.
TIMEOUT_CYCLES, 0, BUSY cycles before abort; 0 disables the timeout.

Ports:
clk  input  1  clock
rst_n  input  1  reset; synchronous, active-low
i_request  input  HOSTS  per-host access request; level, held until that host's o_done
i_write  input  HOSTS  per-host direction; 1 = write
i_address  input  HOSTS*ADDRESS_WIDTH  per-host address, flattened; host h at slice h
i_write_data  input  HOSTS*DATA_WIDTH  per-host write data, flattened
i_strobe  input  HOSTS*DATA_WIDTH  per-host bit-level write mask, flattened
o_done  output  HOSTS  one-cycle completion pulse to the granted host
o_read_data  output  DATA_WIDTH  response data; valid only while any o_done bit is high
o_status  output  2  response status (rggen_status); valid with o_done
o_grant  output  HOSTS  one-hot current owner; 0 in IDLE
o_busy  output  1  high in BUSY and RESPOND
o_request  output  1  downstream access request
o_write  output  1  downstream direction
o_address  output  ADDRESS_WIDTH  downstream address
o_write_data  output  DATA_WIDTH  downstream write data
o_strobe  output  DATA_WIDTH  downstream write mask
i_done  input  1  downstream completion, one cycle
i_read_data  input  DATA_WIDTH  downstream read data; valid with i_done
i_status  input  2  downstream status; valid with i_done

Behaviour:
- Reset, when rst_n is low at a clk edge:
  - state = IDLE; round-robin pointer = host 0; timeout counter = 0.
  - All outputs are 0.
  - Any in-flight downstream access is abandoned, and no o_done is issued for it.
- All outputs are registered.
- FSM states: IDLE, BUSY, RESPOND.
- IDLE, with any i_request bit high:
  - Pick the first requesting host at or after the pointer, wrapping modulo HOSTS.
  - Latch that host's write, address, write_data and strobe.
  - Set o_grant, o_request and o_busy, and move to BUSY.
  - Latency: request sampled in cycle 0 gives o_request high in cycle 1.
- BUSY:
  - o_request and the latched command are held stable.
  - Host inputs are ignored; a change to i_request of the granted host is a protocol error and is not handled.
  - On i_done: capture i_read_data and i_status, drop o_request, move to RESPOND.
- Timeout, when TIMEOUT_CYCLES > 0:
  - The counter increments every BUSY cycle without i_done.
  - When the counter reaches TIMEOUT_CYCLES: drop o_request, set o_read_data = 0 and o_status = RGGEN_TIMEOUT_ERROR, move to RESPOND.
  - If i_done and the timeout coincide, i_done wins.
- RESPOND, one cycle:
  - o_done[granted] = 1, with o_read_data and o_status.
  - Pointer = granted + 1, wrapping modulo HOSTS.
  - Counter cleared; next state IDLE with o_grant = 0.
- After o_done, the host must drop i_request in the following cycle, or present a new access.
- The same host may be re-granted in the first IDLE cycle only if no other host is requesting.
- Minimum access period is 3 cycles (IDLE, BUSY, RESPOND) when i_done arrives in the first BUSY cycle.
- o_read_data and o_status return to 0 outside RESPOND.
- HOSTS = 1 degenerates to a pass-through sequencer with the same timing.

Decomposition:
- rggen_rtl_pkg gains:
  - typedef enum logic [1:0] rggen_status: RGGEN_OKAY = 0, RGGEN_EXOKAY = 1, RGGEN_SLAVE_ERROR = 2, RGGEN_TIMEOUT_ERROR = 3.
  - A function for round-robin first-set search from a start index.
- Sub-module rggen_round_robin_arbiter, parameter HOSTS:
  - Ports: clk, rst_n, i_request, i_update, o_grant.
  - Combinational one-hot grant from the request vector and pointer.
  - Registered pointer that advances on i_update.

Test Plan:
1. Host 0 write, address 0x0010, data 0xA5A5_0000, strobe 0xFFFF_0000, i_done 2 cycles after o_request -> downstream fields match; o_done = 2'b01 exactly one cycle after i_done; o_status = RGGEN_OKAY.
2. Both hosts request together from reset -> host 0 served first, then host 1; with both held continuously, grants alternate 0,1,0,1.
3. Host 1 read, i_done with i_read_data = 0xDEAD_BEEF and i_status = RGGEN_SLAVE_ERROR -> o_done = 2'b10, o_read_data = 0xDEAD_BEEF, o_status = 2.
4. TIMEOUT_CYCLES = 4, i_done never asserted -> o_request drops after 4 BUSY cycles; o_done pulses with o_status = 3 and o_read_data = 0.
5. TIMEOUT_CYCLES = 4, i_done asserted in BUSY cycle 4 -> response carries i_status and i_read_data, not a timeout.
6. rst_n low for one cycle while BUSY -> all outputs 0 next cycle, no o_done issued, and next grant goes to host 0.
